// File: rtl/arlet6502_bus_ctrl_if.sv
// -----------------------------------------------------------------------------
// arlet6502_bus_ctrl_if
//   Bundles the CPU-side, memory-side and interrupt-source signals handled by
//   arlet6502_bus_ctrl.
//
//   Modports:
//     slave  - the bus controller. It takes the CPU address/data/write, the
//              memory read data, ext_rdy and the IRQ/NMI sources. It drives the
//              CPU read data, RDY/IRQ/NMI and the memory address/data/write.
//     master - the surrounding system (CPU core plus memory), with the
//              opposite directions.
//
//   Parameters: ADDR_W (address width), N_IRQ (IRQ source count).
// -----------------------------------------------------------------------------
interface arlet6502_bus_ctrl_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned N_IRQ  = 8
);
   logic [ADDR_W-1:0] cpu_A;
   logic [7:0]        cpu_DO;
   logic              cpu_WE;
   logic [7:0]        cpu_DI;
   logic              cpu_RDY;
   logic              cpu_IRQ;
   logic              cpu_NMI;
   logic [ADDR_W-1:0] mem_A;
   logic [7:0]        mem_DO;
   logic              mem_WE;
   logic [7:0]        mem_DI;
   logic              ext_rdy;
   logic [N_IRQ-1:0]  irq_src;
   logic              nmi_src;

   modport slave (
      input  cpu_A, cpu_DO, cpu_WE, mem_DI, ext_rdy, irq_src, nmi_src,
      output cpu_DI, cpu_RDY, cpu_IRQ, cpu_NMI, mem_A, mem_DO, mem_WE
   );

   modport master (
      output cpu_A, cpu_DO, cpu_WE, mem_DI, ext_rdy, irq_src, nmi_src,
      input  cpu_DI, cpu_RDY, cpu_IRQ, cpu_NMI, mem_A, mem_DO, mem_WE
   );
endinterface

// File: rtl/arlet6502_bus_ctrl.sv
// -----------------------------------------------------------------------------
// arlet6502_bus_ctrl
//   Bus controller between the arlet6502 core and system memory.
//   - Stalls the core (RDY low) for a programmable or fixed number of cycles on
//     accesses to the slow address window.
//   - Collects up to 8 edge-triggered IRQ sources into PEND/MASK registers that
//     are mapped into CPU space at CTRL_BASE (+0 PEND, +1 MASK, +2 WAIT, +3 zero).
//   - Registers the NMI source toward the core.
//
//   Ports:
//     clk    - CPU clock; all state changes on the rising edge
//     reset  - synchronous, active-high
//     bus    - arlet6502_bus_ctrl_if.slave (CPU bus, memory bus, ext_rdy,
//              irq_src, nmi_src)
//
//   Build option:
//     BUS_CTRL_PROG_WAIT_EN - when defined, +2 is a read/write wait-count
//     register (low 4 bits, resets to WAIT_CYCLES). When undefined, +2 reads
//     WAIT_CYCLES[3:0], ignores writes, and the count is the constant.
// -----------------------------------------------------------------------------
module arlet6502_bus_ctrl #(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       N_IRQ       = 8,
   parameter int unsigned       WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] SLOW_BASE   = 16'hC000,
   parameter logic [ADDR_W-1:0] SLOW_MASK   = 16'hF000,
   parameter logic [ADDR_W-1:0] CTRL_BASE   = 16'hFE00
) (
   input logic                  clk,
   input logic                  reset,
   arlet6502_bus_ctrl_if.slave  bus
);

   localparam logic [3:0] WAIT_DEF = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] irq_q;
   logic             cpu_irq_q;
   logic             nmi_q;
   logic             sel_q;
   logic [1:0]       off_q;

   logic             ctrl_hit;
   logic             slow_hit;
   logic             rdy;
   logic             ctrl_wr;
   logic [3:0]       wait_cnt;
   logic [N_IRQ-1:0] irq_rise;
   logic [7:0]       pend_rd;
   logic [7:0]       mask_rd;
   logic [7:0]       wait_rd;
   logic [7:0]       reg_rd;

   // ---------------- address decode and bus pass-through ----------------
   assign ctrl_hit = (bus.cpu_A[ADDR_W-1:2] == CTRL_BASE[ADDR_W-1:2]);
   assign slow_hit = ((bus.cpu_A & SLOW_MASK) == SLOW_BASE) && !ctrl_hit;
   assign rdy      = bus.ext_rdy && (state_q != ST_WAIT);
   assign ctrl_wr  = bus.cpu_WE && ctrl_hit && rdy;

   assign bus.cpu_RDY = rdy;
   assign bus.mem_A   = bus.cpu_A;
   assign bus.mem_DO  = bus.cpu_DO;
   // Control-block writes are absorbed here and never reach memory.
   assign bus.mem_WE  = bus.cpu_WE && !ctrl_hit && rdy;
   assign bus.cpu_IRQ = cpu_irq_q;
   assign bus.cpu_NMI = nmi_q;

   // ---------------- wait-count source ----------------
`ifdef BUS_CTRL_PROG_WAIT_EN
   logic [3:0] wait_q, wait_d;

   always_comb begin
      wait_d = wait_q;
      if (ctrl_wr && (bus.cpu_A[1:0] == 2'd2)) begin
         wait_d = bus.cpu_DO[3:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q <= WAIT_DEF;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign wait_cnt = wait_q;
`else
   assign wait_cnt = WAIT_DEF;
`endif

   // ---------------- wait-state FSM ----------------
   // A slow access seen with RDY high loads cnt = count-1, so RDY is held low
   // for exactly count cycles. DONE releases RDY for one advancing cycle before
   // the FSM can rearm, so back-to-back slow accesses each get their stall.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (slow_hit && rdy && (wait_cnt != 4'd0)) begin
               state_d = ST_WAIT;
               cnt_d   = wait_cnt - 4'd1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            // Hold DONE until the core actually advances.
            if (bus.ext_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------- IRQ pending / mask ----------------
   assign irq_rise = bus.irq_src & ~irq_q;

   // The new-edge OR is applied after the write-1-clear so a set always wins.
   always_comb begin
      pend_d = pend_q;
      mask_d = mask_q;
      if (ctrl_wr && (bus.cpu_A[1:0] == 2'd0)) begin
         pend_d = pend_q & ~bus.cpu_DO[N_IRQ-1:0];
      end
      if (ctrl_wr && (bus.cpu_A[1:0] == 2'd1)) begin
         mask_d = bus.cpu_DO[N_IRQ-1:0];
      end
      pend_d = pend_d | irq_rise;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q    <= '0;
         mask_q    <= '0;
         irq_q     <= '0;
         cpu_irq_q <= 1'b0;
         nmi_q     <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         irq_q     <= bus.irq_src;
         cpu_irq_q <= |(pend_q & mask_q);
         nmi_q     <= bus.nmi_src;
      end
   end

   // ---------------- read path ----------------
   // The core samples DI one cycle after driving the address, so the register
   // select is captured on each advancing cycle and used on the next.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= 1'b0;
         off_q <= 2'd0;
      end else if (rdy) begin
         sel_q <= ctrl_hit;
         off_q <= bus.cpu_A[1:0];
      end
   end

   always_comb begin
      pend_rd              = 8'd0;
      mask_rd              = 8'd0;
      wait_rd              = 8'd0;
      pend_rd[N_IRQ-1:0]   = pend_q;
      mask_rd[N_IRQ-1:0]   = mask_q;
      wait_rd[3:0]         = wait_cnt;
      case (off_q)
         2'd0:    reg_rd = pend_rd;
         2'd1:    reg_rd = mask_rd;
         2'd2:    reg_rd = wait_rd;
         default: reg_rd = 8'd0;
      endcase
   end

   assign bus.cpu_DI = sel_q ? reg_rd : bus.mem_DI;

endmodule
